// File: rtl/fp_mul_newton_pipe.sv
// Three-stage positive-float multiplier for the Newton step y * (1.5 - h) of the invsqrt pipe.
// Define FP_MUL_ROUND_EN for round-to-nearest-even; the default build truncates.
module fp_mul_newton_pipe #(
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             backprn,
  input  logic             valid_in,
  input  logic [30:0]      a_in,
  input  logic [30:0]      b_in,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             error_in,
  output logic [30:0]      float_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             ready,
  output logic             error_out
);

`ifdef FP_MUL_ROUND_EN
  localparam int unsigned PLsb = 0;
`else
  localparam int unsigned PLsb = 23;
`endif
  localparam int unsigned PW = 48 - PLsb;

  // Stage 1: registered operands
  logic             r1_valid;
  logic [30:0]      r1_a;
  logic [30:0]      r1_b;
  logic [TAG_W-1:0] r1_tag;
  logic             r1_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r1_a     <= '0;
      r1_b     <= '0;
      r1_tag   <= '0;
      r1_err   <= 1'b0;
    end else if (backprn) begin
      r1_valid <= valid_in;
      r1_a     <= a_in;
      r1_b     <= b_in;
      r1_tag   <= tag_in;
      r1_err   <= error_in;
    end
  end

  logic [23:0]        w_ma;
  logic [23:0]        w_mb;
  logic [PW-1:0]      w_prod;
  logic signed [9:0]  w_esum;
  logic               w_zero;
  logic               w_spec;

  assign w_ma   = {1'b1, r1_a[22:0]};
  assign w_mb   = {1'b1, r1_b[22:0]};
  // Product bits below the guard position are only kept when rounding needs them.
  assign w_prod = PW'((48'(w_ma) * 48'(w_mb)) >> PLsb);
  assign w_esum = $signed({2'b00, r1_a[30:23]}) + $signed({2'b00, r1_b[30:23]}) - 10'sd127;
  assign w_zero = (r1_a[30:23] == 8'd0) || (r1_b[30:23] == 8'd0);
  assign w_spec = (r1_a[30:23] == 8'hFF) || (r1_b[30:23] == 8'hFF);

  // Stage 2: raw product and biased exponent sum
  logic             r2_valid;
  logic [47:PLsb]   r2_prod;
  logic signed [9:0] r2_exp;
  logic             r2_zero;
  logic             r2_spec;
  logic [TAG_W-1:0] r2_tag;
  logic             r2_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_valid <= 1'b0;
      r2_prod  <= '0;
      r2_exp   <= '0;
      r2_zero  <= 1'b0;
      r2_spec  <= 1'b0;
      r2_tag   <= '0;
      r2_err   <= 1'b0;
    end else if (backprn) begin
      r2_valid <= r1_valid;
      r2_prod  <= w_prod;
      r2_exp   <= w_esum;
      r2_zero  <= w_zero;
      r2_spec  <= w_spec;
      r2_tag   <= r1_tag;
      r2_err   <= r1_err;
    end
  end

  logic              w_norm;
  logic [23:0]       w_mant24;
  logic              w_inc;
  logic [24:0]       w_rnd;
  logic              w_carry;
  logic [22:0]       w_mant;
  logic signed [9:0] w_exp;
  logic [30:0]       w_res;
  logic              w_res_err;

  assign w_norm   = r2_prod[47];
  assign w_mant24 = w_norm ? r2_prod[47:24] : r2_prod[46:23];

`ifdef FP_MUL_ROUND_EN
  logic w_guard;
  logic w_sticky;
  assign w_guard  = w_norm ? r2_prod[23] : r2_prod[22];
  assign w_sticky = w_norm ? (|r2_prod[22:0]) : (|r2_prod[21:0]);
  assign w_inc    = w_guard & (w_sticky | w_mant24[0]);
`else
  assign w_inc    = 1'b0;
`endif

  assign w_rnd   = {1'b0, w_mant24} + {24'd0, w_inc};
  assign w_carry = w_rnd[24];
  // A carry out leaves 1.000..0 * 2, so the stored fraction is all zeros.
  assign w_mant  = w_carry ? w_rnd[23:1] : w_rnd[22:0];
  assign w_exp   = r2_exp + $signed({9'd0, w_norm}) + $signed({9'd0, w_carry});

  always_comb begin
    w_res     = {w_exp[7:0], w_mant};
    w_res_err = r2_err;
    if (r2_spec) begin
      w_res     = 31'h7F800000;
      w_res_err = 1'b1;
    end else if (r2_zero || (w_exp <= 10'sd0)) begin
      w_res     = '0;
    end else if (w_exp >= 10'sd255) begin
      w_res     = 31'h7F800000;
      w_res_err = 1'b1;
    end
  end

  // Stage 3: output register; bubbles clear ready but hold the last result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready     <= 1'b0;
      float_out <= '0;
      tag_out   <= '0;
      error_out <= 1'b0;
    end else if (backprn) begin
      ready <= r2_valid;
      if (r2_valid) begin
        float_out <= w_res;
        tag_out   <= r2_tag;
        error_out <= w_res_err;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_newton_pipe.sv
// Directed bench for fp_mul_newton_pipe: vector table, stall stream and mid-stream reset.
module tb_fp_mul_newton_pipe;
  localparam int unsigned TAG_W = 8;
  localparam int          NVEC  = 14;

  logic             clk;
  logic             rst;
  logic             backprn;
  logic             valid_in;
  logic [30:0]      a_in;
  logic [30:0]      b_in;
  logic [TAG_W-1:0] tag_in;
  logic             error_in;
  logic [30:0]      float_out;
  logic [TAG_W-1:0] tag_out;
  logic             ready;
  logic             error_out;

  fp_mul_newton_pipe #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .backprn   (backprn),
    .valid_in  (valid_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .tag_in    (tag_in),
    .error_in  (error_in),
    .float_out (float_out),
    .tag_out   (tag_out),
    .ready     (ready),
    .error_out (error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [30:0] a;
    logic [30:0] b;
    logic        err_in;
    logic [30:0] exp_f;
    logic        exp_e;
  } vec_t;

  vec_t vecs [NVEC];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [30:0]      snap_f;
    logic             snap_r;
    logic [TAG_W-1:0] snap_t;
    int               idx;
    int               got;
    int               bp_sched [12];
    logic [30:0]      exp_stream;

    vecs[0]  = '{31'h3F800000, 31'h3F800000, 1'b0, 31'h3F800000, 1'b0};
    vecs[1]  = '{31'h3FC00000, 31'h3FC00000, 1'b0, 31'h40100000, 1'b0};
`ifdef FP_MUL_ROUND_EN
    vecs[2]  = '{31'h3F800001, 31'h3FC00000, 1'b0, 31'h3FC00002, 1'b0};
    vecs[3]  = '{31'h3F918E00, 31'h3FE12000, 1'b0, 31'h40000000, 1'b0};
    vecs[4]  = '{31'h3F800001, 31'h3FC00001, 1'b0, 31'h3FC00003, 1'b0};
`else
    vecs[2]  = '{31'h3F800001, 31'h3FC00000, 1'b0, 31'h3FC00001, 1'b0};
    vecs[3]  = '{31'h3F918E00, 31'h3FE12000, 1'b0, 31'h3FFFFFFF, 1'b0};
    vecs[4]  = '{31'h3F800001, 31'h3FC00001, 1'b0, 31'h3FC00002, 1'b0};
`endif
    vecs[5]  = '{31'h3F800003, 31'h3FC00000, 1'b0, 31'h3FC00004, 1'b0};
    vecs[6]  = '{31'h7F000000, 31'h40000000, 1'b0, 31'h7F800000, 1'b1};
    vecs[7]  = '{31'h00800000, 31'h3F000000, 1'b0, 31'h00000000, 1'b0};
    vecs[8]  = '{31'h3F800000, 31'h40000000, 1'b1, 31'h40000000, 1'b1};
    vecs[9]  = '{31'h00000000, 31'h3F800000, 1'b0, 31'h00000000, 1'b0};
    vecs[10] = '{31'h7F800000, 31'h3F800000, 1'b0, 31'h7F800000, 1'b1};
    vecs[11] = '{31'h40000000, 31'h40400000, 1'b0, 31'h40C00000, 1'b0};
    vecs[12] = '{31'h3F800001, 31'h3F800001, 1'b0, 31'h3F800002, 1'b0};
    vecs[13] = '{31'h00400000, 31'h3F800000, 1'b0, 31'h00000000, 1'b0};

    rst      = 1'b1;
    backprn  = 1'b1;
    valid_in = 1'b0;
    a_in     = '0;
    b_in     = '0;
    tag_in   = '0;
    error_in = 1'b0;
    tick();
    tick();
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_float", {1'b0, float_out}, 32'd0);
    chk("reset_tag", {24'd0, tag_out}, 32'd0);
    chk("reset_err", {31'd0, error_out}, 32'd0);
    rst = 1'b0;
    tick();

    // Each vector travels alone so latency and bubble hold are checked too.
    for (int i = 0; i < NVEC; i++) begin
      a_in     = vecs[i].a;
      b_in     = vecs[i].b;
      error_in = vecs[i].err_in;
      tag_in   = TAG_W'(8'h40 + i);
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      error_in = 1'b0;
      tick();
      chk($sformatf("v%0d_early_ready", i), {31'd0, ready}, 32'd0);
      tick();
      chk($sformatf("v%0d_ready", i), {31'd0, ready}, 32'd1);
      chk($sformatf("v%0d_float", i), {1'b0, float_out}, {1'b0, vecs[i].exp_f});
      chk($sformatf("v%0d_err", i), {31'd0, error_out}, {31'd0, vecs[i].exp_e});
      chk($sformatf("v%0d_tag", i), {24'd0, tag_out}, 32'(8'h40 + i));
      tick();
      chk($sformatf("v%0d_bubble_ready", i), {31'd0, ready}, 32'd0);
      chk($sformatf("v%0d_bubble_hold", i), {1'b0, float_out}, {1'b0, vecs[i].exp_f});
    end

    // Five-sample stream with a two-cycle stall after the second sample.
    bp_sched = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    idx = 1;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      backprn = bp_sched[c][0];
      if (idx <= 5) begin
        valid_in = 1'b1;
        a_in     = 31'((127 + idx) << 23);
        b_in     = 31'h3FC00000;
        tag_in   = TAG_W'(idx);
      end else begin
        valid_in = 1'b0;
      end
      snap_f = float_out;
      snap_r = ready;
      snap_t = tag_out;
      tick();
      if (backprn) begin
        if (idx <= 5) idx++;
        if (ready) begin
          got++;
          exp_stream = 31'((127 + got) << 23) | 31'h00400000;
          chk($sformatf("s%0d_float", got), {1'b0, float_out}, {1'b0, exp_stream});
          chk($sformatf("s%0d_tag", got), {24'd0, tag_out}, 32'(got));
          chk($sformatf("s%0d_err", got), {31'd0, error_out}, 32'd0);
        end
      end else begin
        chk($sformatf("stall%0d_float", c), {1'b0, float_out}, {1'b0, snap_f});
        chk($sformatf("stall%0d_ready", c), {31'd0, ready}, {31'd0, snap_r});
        chk($sformatf("stall%0d_tag", c), {24'd0, tag_out}, {24'd0, snap_t});
      end
    end
    chk("stream_count", 32'(got), 32'd5);
    backprn  = 1'b1;
    valid_in = 1'b0;
    tick();

    // Mid-stream reset coinciding with a stall; reset must win.
    for (int k = 0; k < 3; k++) begin
      valid_in = 1'b1;
      a_in     = 31'h3F800000;
      b_in     = 31'h40000000;
      tag_in   = TAG_W'(8'h90 + k);
      tick();
    end
    chk("pre_rst_ready", {31'd0, ready}, 32'd1);
    rst     = 1'b1;
    backprn = 1'b0;
    #2;
    chk("rst_async_ready", {31'd0, ready}, 32'd0);
    chk("rst_async_float", {1'b0, float_out}, 32'd0);
    tick();
    chk("rst_edge_ready", {31'd0, ready}, 32'd0);
    rst      = 1'b0;
    backprn  = 1'b1;
    valid_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("post_rst%0d_ready", k), {31'd0, ready}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
